// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with first-word fall-through read data,
// occupancy count, programmable almost flags, flush and sticky error flags.
module fifo_sync_param #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 3,
    parameter int AFULL_THRESH  = 2**ADDR_WIDTH - 1,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic                  rd,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  flush,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_C   = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   AFULL_C   = AFULL_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   AEMPTY_C  = AEMPTY_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_ZERO  = '0;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  afull_q, afull_d;
    logic                  aempty_q, aempty_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;

    logic pushOk;
    logic popOk;

    // Acceptance is gated by the registered flags; flush suppresses both.
    assign pushOk = wr && !full_q && !flush;
    assign popOk  = rd && !empty_q && !flush;

    always_comb begin
        waddr_d = waddr_q;
        raddr_d = raddr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;

        if (flush) begin
            waddr_d = '0;
            raddr_d = '0;
            count_d = '0;
        end else begin
            if (pushOk) waddr_d = waddr_q + PTR_ONE;
            if (popOk)  raddr_d = raddr_q + PTR_ONE;
            if (pushOk && !popOk)      count_d = count_q + CNT_ONE;
            else if (popOk && !pushOk) count_d = count_q - CNT_ONE;
        end

        // Clear first so that a fresh error in the same cycle wins.
        if (err_clr) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (!flush && wr && full_q)  ovf_d = 1'b1;
        if (!flush && rd && empty_q) udf_d = 1'b1;

        full_d   = (count_d == DEPTH_C);
        empty_d  = (count_d == CNT_ZERO);
        afull_d  = (count_d >= AFULL_C);
        aempty_d = (count_d <= AEMPTY_C);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            waddr_q  <= '0;
            raddr_q  <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= (CNT_ZERO >= AFULL_C);
            aempty_q <= (CNT_ZERO <= AEMPTY_C);
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            waddr_q  <= waddr_d;
            raddr_q  <= raddr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!rst && pushOk) mem[waddr_q] <= wdata;
    end

    assign rdata        = mem[raddr_q];
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed self-checking bench for fifo_sync_param: default byte FIFO plus a
// 16-bit, 16-deep instance exercised with streaming push/pop across wrap.
module tb_fifo_sync_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr, rd, flush, errClr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        full, empty, aFull, aEmpty, ovf, udf;
    logic [3:0]  count;

    logic        wrB, rdB, flushB, errClrB;
    logic [15:0] wdataB, rdataB;
    logic        fullB, emptyB, aFullB, aEmptyB, ovfB, udfB;
    logic [4:0]  countB;

    int total = 0;
    int bad   = 0;
    logic [15:0] modelQ [$];

    always #5 clk = ~clk;

    fifo_sync_param dutA (
        .clk(clk), .rst(rst), .wr(wr), .rd(rd), .wdata(wdata), .flush(flush),
        .err_clr(errClr), .rdata(rdata), .full(full), .empty(empty),
        .almost_full(aFull), .almost_empty(aEmpty), .count(count),
        .overflow(ovf), .underflow(udf)
    );

    fifo_sync_param #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dutB (
        .clk(clk), .rst(rst), .wr(wrB), .rd(rdB), .wdata(wdataB), .flush(flushB),
        .err_clr(errClrB), .rdata(rdataB), .full(fullB), .empty(emptyB),
        .almost_full(aFullB), .almost_empty(aEmptyB), .count(countB),
        .overflow(ovfB), .underflow(udfB)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs on the falling edge, then settle past the rising edge.
    task automatic applyStimulus(input logic w, input logic r, input logic [7:0] d,
                                 input logic f, input logic c);
        @(negedge clk);
        wr = w; rd = r; wdata = d; flush = f; errClr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulusB(input logic w, input logic r, input logic [15:0] d);
        @(negedge clk);
        wrB = w; rdB = r; wdataB = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] v;
        rst = 1'b1;
        wr = 0; rd = 0; wdata = 0; flush = 0; errClr = 0;
        wrB = 0; rdB = 0; wdataB = 0; flushB = 0; errClrB = 0;
        @(posedge clk); #1;
        checkOutput("rst_empty",  32'(empty),  32'd1);
        checkOutput("rst_full",   32'(full),   32'd0);
        checkOutput("rst_afull",  32'(aFull),  32'd0);
        checkOutput("rst_aempty", 32'(aEmpty), 32'd1);
        checkOutput("rst_count",  32'(count),  32'd0);
        checkOutput("rst_ovf",    32'(ovf),    32'd0);
        checkOutput("rst_udf",    32'(udf),    32'd0);
        checkOutput("rstB_count", 32'(countB), 32'd0);
        checkOutput("rstB_empty", 32'(emptyB), 32'd1);
        @(negedge clk); rst = 1'b0;

        // Fill with 0x01..0x08
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1, 0, 8'(k), 0, 0);
            checkOutput("fill_count",  32'(count),  32'(k));
            checkOutput("fill_full",   32'(full),   32'(k == 8));
            checkOutput("fill_afull",  32'(aFull),  32'(k >= 7));
            checkOutput("fill_aempty", 32'(aEmpty), 32'(k <= 1));
            checkOutput("fill_empty",  32'(empty),  32'd0);
            checkOutput("fill_head",   32'(rdata),  32'h01);
        end

        // Overflow while full, then clear
        applyStimulus(1, 0, 8'hAA, 0, 0);
        checkOutput("ovf_set",   32'(ovf),   32'd1);
        checkOutput("ovf_count", 32'(count), 32'd8);
        checkOutput("ovf_head",  32'(rdata), 32'h01);
        applyStimulus(0, 0, 8'h00, 0, 1);
        checkOutput("ovf_clr",   32'(ovf),   32'd0);

        // Drain in order
        for (int k = 1; k <= 8; k++) begin
            checkOutput("drain_data", 32'(rdata), 32'(k));
            applyStimulus(0, 1, 8'h00, 0, 0);
            checkOutput("drain_count", 32'(count), 32'(8 - k));
        end
        checkOutput("drain_empty", 32'(empty), 32'd1);
        checkOutput("drain_udf",   32'(udf),   32'd0);

        // Simultaneous push/pop on empty: push only, underflow
        applyStimulus(1, 1, 8'h5C, 0, 0);
        checkOutput("e_wrrd_count", 32'(count), 32'd1);
        checkOutput("e_wrrd_udf",   32'(udf),   32'd1);
        checkOutput("e_wrrd_data",  32'(rdata), 32'h5C);
        checkOutput("e_wrrd_empty", 32'(empty), 32'd0);
        applyStimulus(0, 1, 8'h00, 0, 1);
        checkOutput("udf_clr",       32'(udf),   32'd0);
        checkOutput("udf_clr_count", 32'(count), 32'd0);
        // Clear and new underflow together: set wins
        applyStimulus(0, 1, 8'h00, 0, 1);
        checkOutput("udf_setwins", 32'(udf), 32'd1);
        applyStimulus(0, 0, 8'h00, 0, 1);
        checkOutput("udf_clr2", 32'(udf), 32'd0);

        // Full with simultaneous push/pop: pop only, overflow
        for (int k = 0; k < 8; k++) applyStimulus(1, 0, 8'(8'h10 + k), 0, 0);
        checkOutput("f2_full", 32'(full), 32'd1);
        applyStimulus(1, 1, 8'hEE, 0, 0);
        checkOutput("f_wrrd_count", 32'(count), 32'd7);
        checkOutput("f_wrrd_full",  32'(full),  32'd0);
        checkOutput("f_wrrd_ovf",   32'(ovf),   32'd1);
        checkOutput("f_wrrd_head",  32'(rdata), 32'h11);
        applyStimulus(0, 0, 8'h00, 0, 1);

        // Flush from count 7, then fill to 5 and flush with requests pending
        applyStimulus(1, 0, 8'h77, 1, 0);
        checkOutput("flush1_count", 32'(count), 32'd0);
        for (int k = 0; k < 5; k++) applyStimulus(1, 0, 8'(8'h21 + k), 0, 0);
        checkOutput("pre_flush_count", 32'(count), 32'd5);
        applyStimulus(1, 1, 8'h99, 1, 0);
        checkOutput("flush_count",  32'(count),  32'd0);
        checkOutput("flush_empty",  32'(empty),  32'd1);
        checkOutput("flush_full",   32'(full),   32'd0);
        checkOutput("flush_aempty", 32'(aEmpty), 32'd1);
        checkOutput("flush_ovf",    32'(ovf),    32'd0);
        checkOutput("flush_udf",    32'(udf),    32'd0);
        // Request during flush on an empty FIFO must not raise underflow
        applyStimulus(0, 1, 8'h00, 1, 0);
        checkOutput("flush_rd_udf", 32'(udf), 32'd0);
        applyStimulus(1, 0, 8'h31, 0, 0);
        checkOutput("post_flush_data",  32'(rdata), 32'h31);
        checkOutput("post_flush_count", 32'(count), 32'd1);
        applyStimulus(0, 1, 8'h00, 0, 0);
        checkOutput("post_flush_empty", 32'(empty), 32'd1);

        // Reset mid-operation discards contents
        applyStimulus(1, 0, 8'h41, 0, 0);
        applyStimulus(1, 0, 8'h42, 0, 0);
        @(negedge clk); rst = 1'b1; wr = 0;
        @(posedge clk); #1;
        checkOutput("mid_rst_count", 32'(count), 32'd0);
        checkOutput("mid_rst_empty", 32'(empty), 32'd1);
        @(negedge clk); rst = 1'b0;
        applyStimulus(1, 0, 8'h43, 0, 0);
        checkOutput("mid_rst_head", 32'(rdata), 32'h43);

        // Wide/deep instance: prime to 3, then stream 40 cycles across wrap
        for (int k = 0; k < 3; k++) begin
            v = 16'($urandom);
            modelQ.push_back(v);
            applyStimulusB(1, 0, v);
        end
        checkOutput("B_prime_count", 32'(countB), 32'd3);
        for (int k = 0; k < 40; k++) begin
            v = 16'($urandom);
            checkOutput("B_stream_data", 32'(rdataB), 32'(modelQ[0]));
            void'(modelQ.pop_front());
            modelQ.push_back(v);
            applyStimulusB(1, 1, v);
            checkOutput("B_stream_count", 32'(countB), 32'd3);
        end
        for (int k = 0; k < 3; k++) begin
            checkOutput("B_drain_data", 32'(rdataB), 32'(modelQ[0]));
            void'(modelQ.pop_front());
            applyStimulusB(0, 1, 16'h0);
        end
        checkOutput("B_drain_empty", 32'(emptyB), 32'd1);
        checkOutput("B_ovf", 32'(ovfB), 32'd0);
        checkOutput("B_udf", 32'(udfB), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
